pong_ball_ctrl: RTL
===================

Name: pong_ball_ctrl

Overview:
Parametrised successor to the free-running bouncing-ball block for the VGA pong game. It moves a one-cell ball on a GAME_WIDTH x GAME_HEIGHT grid and bounces it off the top and bottom walls. It bounces the ball off two player paddles, detects misses and emits score pulses. It re-serves on request and speeds the ball up on every paddle hit. It sits between the paddle controllers and the pixel/tile renderer; o_draw feeds the renderer's colour mux.

Parameters:
GAME_WIDTH, 40, grid columns; x range 0..GAME_WIDTH-1; column 0 is the left paddle, column GAME_WIDTH-1 is the right paddle.
GAME_HEIGHT, 30, grid rows; y range 0..GAME_HEIGHT-1.
COORD_W, 6, width of all coordinate ports and registers.
TICK_W, 25, width of the move-period counter.
START_PERIOD, 5000000, clock cycles per move after serve/reset.
MIN_PERIOD, 1000000, floor for the move period.
SPEEDUP_STEP, 250000, period decrement applied per paddle hit.
PADDLE_HEIGHT, 6, paddle length in rows, starting at the paddle's top y.

Ports:
i_clk  in  1  system clock.
i_rst_n  in  1  asynchronous active-low reset.
i_enabled  in  1  game enable; low forces IDLE.
i_serve  in  1  single-cycle pulse; launches the ball from SERVE.
i_paddle1_y  in  COORD_W  top row of the left paddle.
i_paddle2_y  in  COORD_W  top row of the right paddle.
i_col  in  COORD_W  renderer column being drawn.
i_row  in  COORD_W  renderer row being drawn.
o_draw  out  1  registered; ball occupies (i_col,i_row).
o_ball_x  out  COORD_W  current ball column.
o_ball_y  out  COORD_W  current ball row.
o_ball_direction  out  2  bit0 1=east/0=west, bit1 1=north/0=south.
o_score_p1  out  1  one-cycle pulse; right player missed.
o_score_p2  out  1  one-cycle pulse; left player missed.
o_playing  out  1  high in PLAY.

Behaviour:
- Reset (async, i_rst_n=0) sets: state IDLE; x=GAME_WIDTH/2; y=GAME_HEIGHT/2; direction 2'b00; period=START_PERIOD; tick counter 0; all outputs 0 except o_ball_x/o_ball_y, which carry the centre values.
- States: IDLE, SERVE, PLAY, SCORED. Whenever i_enabled=0, the next state is IDLE from any state, and the ball is recentred, direction set to 00, period set to START_PERIOD.
- IDLE -> SERVE when i_enabled=1.
- SERVE: ball held at centre. i_serve=1 moves to PLAY and clears the tick counter.
- PLAY: the counter counts 0..period-1. At count==period-1 a move occurs and the counter returns to 0. The first move is therefore exactly `period` cycles after entering PLAY.
- Vertical move: if moving north at y==0, flip to south; if moving south at y==GAME_HEIGHT-1, flip to north. Then step y by 1 in the resulting direction. The ball never leaves 0..GAME_HEIGHT-1.
- Left edge, moving west at x==1:
  - Hit when i_paddle1_y <= y <= i_paddle1_y+PADDLE_HEIGHT-1, compared at COORD_W+1 bits (no wrap). Uses y before this move's vertical step.
  - On a hit: set bit0=1 and x=2, and set period = max(period-SPEEDUP_STEP, MIN_PERIOD) with no underflow.
  - On a miss: x=0, go to SCORED.
- Right edge, moving east at x==GAME_WIDTH-2: same rule against i_paddle2_y. A hit sets bit0=0 and x=GAME_WIDTH-3. A miss sets x=GAME_WIDTH-1 and goes to SCORED.
- Otherwise x steps by 1 in the current direction.
- The vertical flip/step and the horizontal handling happen on the same move.
- SCORED lasts exactly 1 cycle:
  - A left miss pulses o_score_p2; a right miss pulses o_score_p1.
  - Next state is SERVE, with the ball recentred and period=START_PERIOD.
  - Direction becomes 00 after a left miss (serve toward the conceding left player) and 01 after a right miss.
- Paddle inputs are sampled only at move cycles.
- o_draw is asserted 1 cycle after (i_col,i_row) equals the current (x,y), in every state except IDLE. In IDLE it is 0.
- i_serve outside SERVE is ignored.

Test Plan:
All scenarios use START_PERIOD=4, MIN_PERIOD=2, SPEEDUP_STEP=1, defaults otherwise.
1. Reset, then i_enabled=1 and i_serve pulse -> ball (20,15), dir 00. First move 4 cycles after PLAY entry gives (19,16). A move occurs every 4 cycles.
2. Wall bounce: let the ball run -> after move 14 the ball is at (6,29); move 15 flips dir to 10 and gives (5,28).
3. Left paddle hit: i_paddle1_y=20 -> at move 19 the ball is at (1,24). Move 20 gives (2,23), dir 11, and move spacing becomes 3 cycles. After 2 more hits the spacing stays at 2.
4. Left miss: i_paddle1_y=0 -> move 20 gives (0,23). o_score_p2 is high for exactly 1 cycle, then SERVE with ball (20,15) and dir 00. Mirror the scenario on the right paddle -> o_score_p1 pulse and dir 01.
5. Deassert i_enabled mid-PLAY -> next cycle IDLE, ball (20,15), o_draw=0. Assert i_rst_n=0 mid-move -> all state resets immediately (async) and period returns to 4.
6. Renderer: drive i_col/i_row=(20,15) in SERVE -> o_draw=1 exactly one cycle later. Drive (20,16) -> o_draw=0.

Source files
------------

// File: rtl/pong_ball_ctrl.sv
// Ball motion controller for the pong game: moves a one-cell ball on the grid,
// bounces it off walls and paddles, flags misses and speeds up on each paddle hit.
module pong_ball_ctrl #(
    parameter int GAME_WIDTH    = 40,
    parameter int GAME_HEIGHT   = 30,
    parameter int COORD_W       = 6,
    parameter int TICK_W        = 25,
    parameter int START_PERIOD  = 5000000,
    parameter int MIN_PERIOD    = 1000000,
    parameter int SPEEDUP_STEP  = 250000,
    parameter int PADDLE_HEIGHT = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enabled,
    input  logic               i_serve,
    input  logic [COORD_W-1:0] i_paddle1_y,
    input  logic [COORD_W-1:0] i_paddle2_y,
    input  logic [COORD_W-1:0] i_col,
    input  logic [COORD_W-1:0] i_row,
    output logic               o_draw,
    output logic [COORD_W-1:0] o_ball_x,
    output logic [COORD_W-1:0] o_ball_y,
    output logic [1:0]         o_ball_direction,
    output logic               o_score_p1,
    output logic               o_score_p2,
    output logic               o_playing
);

    // state  | meaning
    // IDLE   | game disabled, ball parked at centre, nothing drawn
    // SERVE  | ball held at centre waiting for a serve pulse
    // PLAY   | ball moves once per period
    // SCORED | one-cycle score pulse, then back to SERVE
    typedef enum logic [1:0] {IDLE, SERVE, PLAY, SCORED} state_t;

    localparam logic [COORD_W-1:0] X_CENTRE  = COORD_W'(GAME_WIDTH / 2);
    localparam logic [COORD_W-1:0] Y_CENTRE  = COORD_W'(GAME_HEIGHT / 2);
    localparam logic [COORD_W-1:0] X_LEFT    = COORD_W'(0);
    localparam logic [COORD_W-1:0] X_LEFT_IN = COORD_W'(1);
    localparam logic [COORD_W-1:0] X_LEFT_RB = COORD_W'(2);
    localparam logic [COORD_W-1:0] X_RIGHT    = COORD_W'(GAME_WIDTH - 1);
    localparam logic [COORD_W-1:0] X_RIGHT_IN = COORD_W'(GAME_WIDTH - 2);
    localparam logic [COORD_W-1:0] X_RIGHT_RB = COORD_W'(GAME_WIDTH - 3);
    localparam logic [COORD_W-1:0] Y_TOP     = COORD_W'(0);
    localparam logic [COORD_W-1:0] Y_BOTTOM  = COORD_W'(GAME_HEIGHT - 1);
    localparam logic [COORD_W-1:0] ONE       = COORD_W'(1);
    localparam logic [COORD_W:0]   PAD_SPAN  = (COORD_W+1)'(PADDLE_HEIGHT - 1);
    localparam logic [TICK_W-1:0]  START_P   = TICK_W'(START_PERIOD);
    localparam logic [TICK_W-1:0]  MIN_P     = TICK_W'(MIN_PERIOD);
    localparam logic [TICK_W-1:0]  STEP_P    = TICK_W'(SPEEDUP_STEP);
    localparam logic [TICK_W-1:0]  FLOOR_AT  = TICK_W'(MIN_PERIOD + SPEEDUP_STEP);
    localparam logic [TICK_W-1:0]  TICK_ONE  = TICK_W'(1);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [1:0]         dir_q, dir_d;
    logic [TICK_W-1:0]  period_q, period_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic               draw_q, draw_d;

    logic               v_north;
    logic [COORD_W-1:0] y_step;
    logic [COORD_W:0]   y_ext, p1_top, p1_bot, p2_top, p2_bot;
    logic               hit1, hit2;
    logic [TICK_W-1:0]  period_fast;

    // Move arithmetic, evaluated every cycle and consumed only on a move.
    always_comb begin
        v_north = dir_q[1];
        if (dir_q[1] && (y_q == Y_TOP)) begin
            v_north = 1'b0;
        end else if (!dir_q[1] && (y_q == Y_BOTTOM)) begin
            v_north = 1'b1;
        end
        y_step = v_north ? (y_q - ONE) : (y_q + ONE);

        y_ext  = {1'b0, y_q};
        p1_top = {1'b0, i_paddle1_y};
        p1_bot = p1_top + PAD_SPAN;
        p2_top = {1'b0, i_paddle2_y};
        p2_bot = p2_top + PAD_SPAN;
        hit1   = (y_ext >= p1_top) && (y_ext <= p1_bot);
        hit2   = (y_ext >= p2_top) && (y_ext <= p2_bot);

        period_fast = (period_q >= FLOOR_AT) ? (period_q - STEP_P) : MIN_P;
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dir_d    = dir_q;
        period_d = period_q;
        tick_d   = tick_q;

        case (state_q)
            IDLE: begin
                state_d = SERVE;
            end
            SERVE: begin
                if (i_serve) begin
                    state_d = PLAY;
                    tick_d  = period_q - TICK_ONE;
                end
            end
            PLAY: begin
                if (tick_q == '0) begin
                    y_d      = y_step;
                    dir_d[1] = v_north;
                    if (!dir_q[0] && (x_q == X_LEFT_IN)) begin
                        if (hit1) begin
                            dir_d[0] = 1'b1;
                            x_d      = X_LEFT_RB;
                            period_d = period_fast;
                        end else begin
                            x_d     = X_LEFT;
                            state_d = SCORED;
                        end
                    end else if (dir_q[0] && (x_q == X_RIGHT_IN)) begin
                        if (hit2) begin
                            dir_d[0] = 1'b0;
                            x_d      = X_RIGHT_RB;
                            period_d = period_fast;
                        end else begin
                            x_d     = X_RIGHT;
                            state_d = SCORED;
                        end
                    end else begin
                        x_d = dir_q[0] ? (x_q + ONE) : (x_q - ONE);
                    end
                    // Reload with the possibly sped-up period so the next gap uses it.
                    tick_d = period_d - TICK_ONE;
                end else begin
                    tick_d = tick_q - TICK_ONE;
                end
            end
            SCORED: begin
                state_d  = SERVE;
                x_d      = X_CENTRE;
                y_d      = Y_CENTRE;
                period_d = START_P;
                // Still pointing at the side that missed: serve back toward it.
                dir_d    = {1'b0, dir_q[0]};
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!i_enabled) begin
            state_d  = IDLE;
            x_d      = X_CENTRE;
            y_d      = Y_CENTRE;
            dir_d    = 2'b00;
            period_d = START_P;
        end
    end

    assign draw_d = (state_d != IDLE) && (i_col == x_q) && (i_row == y_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            x_q      <= X_CENTRE;
            y_q      <= Y_CENTRE;
            dir_q    <= 2'b00;
            period_q <= START_P;
            tick_q   <= '0;
            draw_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dir_q    <= dir_d;
            period_q <= period_d;
            tick_q   <= tick_d;
            draw_q   <= draw_d;
        end
    end

    assign o_draw           = draw_q;
    assign o_ball_x         = x_q;
    assign o_ball_y         = y_q;
    assign o_ball_direction = dir_q;
    assign o_playing        = (state_q == PLAY);
    assign o_score_p1       = (state_q == SCORED) && dir_q[0];
    assign o_score_p2       = (state_q == SCORED) && !dir_q[0];

endmodule
